memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Pipeline MEM stage between execute and write-back. Takes the ALU-computed effective address, store data and decoded opcode/funct3, and runs a single load or store transaction against the data cache through a valid/ready request plus response handshake. Returns sign- or zero-extended load data and a level `mem_done` to the write-back stage. Non-memory instructions pass through with a one-cycle done and no cache traffic.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `mem_module_enable`  in  1  level; stage owns an instruction while high
- `opcode`  in  7  decoded opcode; loads are 0000011, stores are 0100011
- `funct3`  in  3  access size and signedness
- `alu_result`  in  64  effective byte address
- `store_data`  in  64  rs2 value, LSB-aligned
- `dcache_req_valid`  out  1  request valid
- `dcache_req_ready`  in  1  cache accepts request
- `dcache_req_write`  out  1  1 = store
- `dcache_req_addr`  out  64  doubleword-aligned address `{alu_result[63:3],3'b0}`
- `dcache_req_wdata`  out  64  store data shifted into byte lanes
- `dcache_req_wstrb`  out  8  byte-lane write mask
- `dcache_resp_valid`  in  1  load data valid or store acknowledged
- `dcache_resp_rdata`  in  64  aligned doubleword
- `loaded_data`  out  64  extended load result; holds until next load completes
- `misaligned`  out  1  access was not size-aligned; no cache request issued
- `mem_done`  out  1  level; instruction finished

## Operation
- FSM states are IDLE, REQ, WAIT and DONE. All outputs are registered.
- IDLE to REQ: `mem_module_enable`=1, the opcode is a load or store, and the access is aligned. The block latches the address, size, signedness, write flag, wdata and wstrb.
- IDLE to DONE: `mem_module_enable`=1 and either the opcode is a non-memory opcode, or the access is misaligned. On a misaligned access, `misaligned` is set to 1 and no request is issued.
- REQ: `dcache_req_valid`=1 with all request fields stable. When `dcache_req_ready`=1, the request transfers that cycle and the FSM moves to WAIT.
- WAIT: on `dcache_resp_valid`=1, go to DONE. For a load, `loaded_data` is captured that same edge.
- DONE: `mem_done`=1, held while enable stays high. When enable falls, go to IDLE; `mem_done` and `misaligned` clear.
- Enable drops during REQ or WAIT: the transaction still completes, because the cache request cannot be aborted. The FSM then returns to IDLE without asserting `mem_done`.
- Size and alignment by funct3[1:0]:
  - 00 = byte, always aligned.
  - 01 = half, requires addr[0]=0.
  - 10 = word, requires addr[1:0]=0.
  - 11 = double, requires addr[2:0]=0.
- Signedness: funct3[2]=1 means zero-extend. funct3 = 111 is treated as a non-memory opcode.
- Store lanes:
  - `wdata` = `store_data << (8*addr[2:0])`.
  - `wstrb` = size mask (0x01, 0x03, 0x0F or 0xFF) `<< addr[2:0]`.
- Load:
  - `shifted = rdata >> (8*addr[2:0])`.
  - Truncate to the access size, then sign- or zero-extend to 64 bits.

## Timing
- Reset (any state, including mid-transaction): FSM returns to IDLE. Every output is 0: `dcache_req_valid`, `dcache_req_write`, `dcache_req_addr`, `dcache_req_wdata`, `dcache_req_wstrb`, `loaded_data`, `misaligned`, `mem_done`. The cache must tolerate an abandoned request.
- `dcache_req_valid` rises 1 cycle after enable is sampled high in IDLE.
- Best-case load or store (ready in the first REQ cycle, response the following cycle): `mem_done` is high 3 cycles after enable is sampled.
- Non-memory or misaligned instruction: `mem_done` is high 1 cycle after enable is sampled.
- `dcache_req_valid` never deasserts before ready is seen. It deasserts the cycle after the handshake.
- A response arriving while in REQ is illegal and is ignored.
- After enable falls, at least one IDLE cycle occurs before the next instruction is accepted.

## Test plan
- LB from 0x1003, rdata = 0x0000_0000_8000_0000 → one read request to 0x1000 → `loaded_data` = 0xFFFF_FFFF_FFFF_FF80; `mem_done` 3 cycles after enable.
- LWU from 0x2004, rdata = 0xDEAD_BEEF_0000_0000, ready held low for 4 cycles → `valid` and `addr` stay stable through the stall → `loaded_data` = 0x0000_0000_DEAD_BEEF.
- SH to 0x3006 with `store_data` = 0x1234 → `wstrb` = 0xC0, `wdata` = 0x1234_0000_0000_0000, `write` = 1, `loaded_data` unchanged.
- LD from 0x4004 → no request issued; `misaligned`=1 and `mem_done`=1 one cycle after enable; both clear when enable falls.
- R-type opcode 0110011 → `mem_done` one cycle after enable; `dcache_req_valid` never rises.
- Reset asserted during WAIT → next cycle all outputs are 0 and the FSM is in IDLE; a following LD from 0x5000 completes normally.

Source files
------------

// File: rtl/memory_access_stage.sv
// Pipeline MEM stage: runs one data-cache load/store per instruction through a valid/ready request and a response.
// Latency: non-memory or misaligned instructions finish 1 cycle after enable; cache accesses take 3+ cycles.
// Backpressure: the request is held stable until ready; enable falling mid-access lets the access finish without a done.
module memory_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_module_enable,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [63:0] alu_result,
    input  logic [63:0] store_data,
    output logic        dcache_req_valid,
    input  logic        dcache_req_ready,
    output logic        dcache_req_write,
    output logic [63:0] dcache_req_addr,
    output logic [63:0] dcache_req_wdata,
    output logic [7:0]  dcache_req_wstrb,
    input  logic        dcache_resp_valid,
    input  logic [63:0] dcache_resp_rdata,
    output logic [63:0] loaded_data,
    output logic        misaligned,
    output logic        mem_done
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state;

    logic        is_load, is_store, is_mem, aligned;
    logic [2:0]  off;
    logic [7:0]  size_mask;
    logic [2:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic        lat_load;
    logic        dropped;
    logic [63:0] shifted, load_ext;

    assign off      = alu_result[2:0];
    assign is_load  = (opcode == OP_LOAD)  && (funct3 != 3'b111);
    assign is_store = (opcode == OP_STORE) && (funct3 != 3'b111);
    assign is_mem   = is_load | is_store;

    always_comb begin
        aligned   = 1'b1;
        size_mask = 8'h01;
        case (funct3[1:0])
            2'b00: begin aligned = 1'b1;           size_mask = 8'h01; end
            2'b01: begin aligned = ~off[0];        size_mask = 8'h03; end
            2'b10: begin aligned = (off[1:0] == 2'b00); size_mask = 8'h0F; end
            default: begin aligned = (off == 3'b000); size_mask = 8'hFF; end
        endcase
    end

    // Extraction uses the latched offset/size: the upstream operands may have moved on.
    assign shifted = dcache_resp_rdata >> {lat_off, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (lat_size)
            2'b00:   load_ext = {{56{~lat_unsigned & shifted[7]}},  shifted[7:0]};
            2'b01:   load_ext = {{48{~lat_unsigned & shifted[15]}}, shifted[15:0]};
            2'b10:   load_ext = {{32{~lat_unsigned & shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            dcache_req_valid <= 1'b0;
            dcache_req_write <= 1'b0;
            dcache_req_addr  <= '0;
            dcache_req_wdata <= '0;
            dcache_req_wstrb <= '0;
            loaded_data      <= '0;
            misaligned       <= 1'b0;
            mem_done         <= 1'b0;
            lat_off          <= '0;
            lat_size         <= '0;
            lat_unsigned     <= 1'b0;
            lat_load         <= 1'b0;
            dropped          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_module_enable) begin
                        if (is_mem && aligned) begin
                            state            <= REQ;
                            dcache_req_valid <= 1'b1;
                            dcache_req_write <= is_store;
                            dcache_req_addr  <= {alu_result[63:3], 3'b000};
                            dcache_req_wdata <= store_data << {off, 3'b000};
                            dcache_req_wstrb <= size_mask << off;
                            lat_off          <= off;
                            lat_size         <= funct3[1:0];
                            lat_unsigned     <= funct3[2];
                            lat_load         <= is_load;
                            dropped          <= 1'b0;
                        end else begin
                            state      <= DONE;
                            mem_done   <= 1'b1;
                            misaligned <= is_mem;
                        end
                    end
                end
                REQ: begin
                    if (!mem_module_enable) dropped <= 1'b1;
                    if (dcache_req_ready) begin
                        dcache_req_valid <= 1'b0;
                        state            <= WAIT;
                    end
                end
                WAIT: begin
                    if (dcache_resp_valid) begin
                        if (lat_load) loaded_data <= load_ext;
                        if (dropped || !mem_module_enable) begin
                            state <= IDLE;
                        end else begin
                            state    <= DONE;
                            mem_done <= 1'b1;
                        end
                    end else if (!mem_module_enable) begin
                        dropped <= 1'b1;
                    end
                end
                default: begin
                    if (!mem_module_enable) begin
                        state      <= IDLE;
                        mem_done   <= 1'b0;
                        misaligned <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed test-plan steps plus randomized instructions against a byte-lane model.
module tb_memory_access_stage;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] RTYPE = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_module_enable;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] alu_result, store_data;
    logic        dcache_req_valid, dcache_req_ready, dcache_req_write;
    logic [63:0] dcache_req_addr, dcache_req_wdata;
    logic [7:0]  dcache_req_wstrb;
    logic        dcache_resp_valid;
    logic [63:0] dcache_resp_rdata, loaded_data;
    logic        misaligned, mem_done;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_loaded = '0;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .clk(clk), .reset(reset), .mem_module_enable(mem_module_enable),
        .opcode(opcode), .funct3(funct3), .alu_result(alu_result), .store_data(store_data),
        .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
        .dcache_req_write(dcache_req_write), .dcache_req_addr(dcache_req_addr),
        .dcache_req_wdata(dcache_req_wdata), .dcache_req_wstrb(dcache_req_wstrb),
        .dcache_resp_valid(dcache_resp_valid), .dcache_resp_rdata(dcache_resp_rdata),
        .loaded_data(loaded_data), .misaligned(misaligned), .mem_done(mem_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, {63'b0, dcache_req_valid}, 64'd0);
        chk({tag, ".write"}, {63'b0, dcache_req_write}, 64'd0);
        chk({tag, ".addr"},  dcache_req_addr, 64'd0);
        chk({tag, ".wdata"}, dcache_req_wdata, 64'd0);
        chk({tag, ".wstrb"}, {56'b0, dcache_req_wstrb}, 64'd0);
        chk({tag, ".ldata"}, loaded_data, 64'd0);
        chk({tag, ".misal"}, {63'b0, misaligned}, 64'd0);
        chk({tag, ".done"},  {63'b0, mem_done}, 64'd0);
    endtask

    function automatic logic [63:0] junk64();
        return {$urandom, $urandom};
    endfunction

    // Reference load: select the bytes at the offset, truncate, extend.
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] rdat);
        int n, off;
        logic [63:0] m, v;
        n   = 1 << f3[1:0];
        off = int'(addr[2:0]);
        m   = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        v   = (rdat >> (8 * off)) & m;
        if (!f3[2] && v[8 * n - 1]) v = v | ~m;
        return v;
    endfunction

    // Starts and ends at a negedge; acts as the cache for memory instructions.
    task automatic do_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] sd, input logic [63:0] rdat,
                            input int rdly, input int sdly, input bit drop);
        bit mem_op, ok;
        int n, off;
        logic [63:0] exp_addr;
        mem_op = ((op == LOAD) || (op == STORE)) && (f3 != 3'b111);
        n      = 1 << f3[1:0];
        off    = int'(addr[2:0]);
        ok     = (off % n) == 0;
        mem_module_enable = 1'b1;
        opcode = op; funct3 = f3; alu_result = addr; store_data = sd;
        @(negedge clk);
        if (!mem_op || !ok) begin
            chk({tag, ".done1"}, {63'b0, mem_done}, 64'd1);
            chk({tag, ".misal"}, {63'b0, misaligned}, {63'b0, mem_op && !ok});
            chk({tag, ".noreq"}, {63'b0, dcache_req_valid}, 64'd0);
            @(negedge clk);
            chk({tag, ".hold"}, {63'b0, mem_done}, 64'd1);
            chk({tag, ".noreq2"}, {63'b0, dcache_req_valid}, 64'd0);
            mem_module_enable = 1'b0;
            @(negedge clk);
            chk({tag, ".clr_done"}, {63'b0, mem_done}, 64'd0);
            chk({tag, ".clr_misal"}, {63'b0, misaligned}, 64'd0);
            return;
        end
        exp_addr = addr & ~64'h7;
        chk({tag, ".valid"}, {63'b0, dcache_req_valid}, 64'd1);
        chk({tag, ".write"}, {63'b0, dcache_req_write}, {63'b0, op == STORE});
        chk({tag, ".addr"}, dcache_req_addr, exp_addr);
        if (op == STORE) begin
            chk({tag, ".wstrb"}, {56'b0, dcache_req_wstrb}, (((64'd1 << n) - 64'd1) << off) & 64'hFF);
            chk({tag, ".wdata"}, dcache_req_wdata, sd << (8 * off));
        end
        alu_result = junk64();
        store_data = junk64();
        if (drop) mem_module_enable = 1'b0;
        for (int k = 0; k < rdly; k++) begin
            dcache_req_ready  = 1'b0;
            dcache_resp_valid = (k == 0);
            dcache_resp_rdata = junk64();
            @(negedge clk);
            chk({tag, ".stall_valid"}, {63'b0, dcache_req_valid}, 64'd1);
            chk({tag, ".stall_addr"}, dcache_req_addr, exp_addr);
        end
        dcache_resp_valid = 1'b0;
        dcache_req_ready  = 1'b1;
        @(negedge clk);
        dcache_req_ready = 1'b0;
        chk({tag, ".valid_drop"}, {63'b0, dcache_req_valid}, 64'd0);
        chk({tag, ".early_done"}, {63'b0, mem_done}, 64'd0);
        for (int k = 0; k < sdly; k++) begin
            @(negedge clk);
            chk({tag, ".wait_done"}, {63'b0, mem_done}, 64'd0);
        end
        dcache_resp_valid = 1'b1;
        dcache_resp_rdata = rdat;
        @(negedge clk);
        dcache_resp_valid = 1'b0;
        dcache_resp_rdata = junk64();
        if (op == LOAD) exp_loaded = ref_load(f3, addr, rdat);
        chk({tag, ".done"}, {63'b0, mem_done}, {63'b0, !drop});
        chk({tag, ".ldata"}, loaded_data, exp_loaded);
        mem_module_enable = 1'b0;
        @(negedge clk);
        chk({tag, ".done_clr"}, {63'b0, mem_done}, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        mem_module_enable = 1'b0;
        opcode = '0; funct3 = '0; alu_result = '0; store_data = '0;
        dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0; dcache_resp_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        do_instr("lb",   LOAD,  3'b000, 64'h1003, '0, 64'h0000_0000_8000_0000, 0, 0, 1'b0);
        chk("lb.value", loaded_data, 64'hFFFF_FFFF_FFFF_FF80);
        do_instr("lwu",  LOAD,  3'b110, 64'h2004, '0, 64'hDEAD_BEEF_0000_0000, 4, 1, 1'b0);
        chk("lwu.value", loaded_data, 64'h0000_0000_DEAD_BEEF);
        do_instr("sh",   STORE, 3'b001, 64'h3006, 64'h1234, junk64(), 1, 2, 1'b0);
        chk("sh.wstrb", {56'b0, dcache_req_wstrb}, 64'hC0);
        chk("sh.wdata", dcache_req_wdata, 64'h1234_0000_0000_0000);
        do_instr("ld_mis", LOAD, 3'b011, 64'h4004, '0, '0, 0, 0, 1'b0);
        do_instr("rtype", RTYPE, 3'b000, 64'h4004, '0, '0, 0, 0, 1'b0);
        do_instr("f3_111", LOAD, 3'b111, 64'h4000, '0, '0, 0, 0, 1'b0);
        do_instr("abort", LOAD,  3'b001, 64'h6002, '0, 64'h0000_0000_F00D_0000, 2, 1, 1'b1);

        // Reset while the load is waiting for its response.
        mem_module_enable = 1'b1;
        opcode = LOAD; funct3 = 3'b011; alu_result = 64'h7000;
        @(negedge clk);
        dcache_req_ready = 1'b1;
        @(negedge clk);
        dcache_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_module_enable = 1'b0;
        chk_zero("rst_wait");
        exp_loaded = '0;
        @(negedge clk);
        do_instr("ld_after_rst", LOAD, 3'b011, 64'h5000, '0, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [6:0]  op;
            logic [2:0]  f3;
            logic [63:0] a;
            int sel;
            sel = $urandom_range(0, 2);
            op  = (sel == 0) ? LOAD : (sel == 1) ? STORE : RTYPE;
            f3  = (op == STORE) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a   = junk64();
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
            do_instr("rand", op, f3, a, junk64(), junk64(),
                     $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
